// File: rtl/hbc_bist_pkg.sv
// Shared types and helpers for the HyperBus memory self-test engine.
// Covers FSM states, pass-size encodings, lane masks and the pattern rotate.
package hbc_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_BYTE = 2'd0;
    localparam logic [1:0] MODE_HALF = 2'd1;
    localparam logic [1:0] MODE_WORD = 2'd2;
    localparam logic [1:0] MODE_ALL  = 2'd3;

    // Byte enables for lane k of a pass whose access size is given by mode.
    function automatic logic [3:0] lane_mask(input logic [1:0] mode, input logic [1:0] k);
        logic [3:0] m;
        case (mode)
            MODE_BYTE: m = 4'b0001 << k;
            MODE_HALF: m = 4'b0011 << {k[0], 1'b0};
            default:   m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

endpackage

// File: rtl/hbc_bist_pattern.sv
// Pattern register: loads SEED or rotates left by ROT, one step per cycle.
// Single-cycle update; no flow control, the caller decides when to step.
module hbc_bist_pattern
    import hbc_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hDEADBEEF,
    parameter int          ROT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        adv,
    output logic [31:0] pat
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat <= '0;
        end else if (load) begin
            pat <= SEED;
        end else if (adv) begin
            pat <= rotl32(pat, 5'(ROT));
        end
    end

endmodule

// File: rtl/hbc_mem_bist.sv
// Write-then-readback self-test for the hbc_wrapper memory port (byte/half/word passes).
// One request in flight; waits for i_mem_ready (bounded by TIMEOUT), then GAP_CYCLES idle.
module hbc_mem_bist
    import hbc_bist_pkg::*;
#(
    parameter int          NUM_WORDS   = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter logic [31:0] SEED        = 32'hDEADBEEF,
    parameter int          ROT         = 4,
    parameter int          VALID_PULSE = 1,
    parameter int          GAP_CYCLES  = 2,
    parameter int          TIMEOUT     = 1023
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [1:0]  i_mode,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic        o_timeout,
    output logic [15:0] o_err_count,
    output logic [31:0] o_err_addr,
    output logic [31:0] o_err_exp,
    output logic [31:0] o_err_got,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic [3:0]  o_mem_wstrb,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    localparam int IW = $clog2(NUM_WORDS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [31:0] HALF_OFS = 32'(4 * NUM_WORDS);
    localparam logic [31:0] WORD_OFS = 32'(8 * NUM_WORDS);

    state_t         state;
    state_t         state_nxt;

    logic [1:0]     cur_mode;
    logic [1:0]     last_mode;
    logic           rd_phase;
    logic [IW-1:0]  idx;
    logic [1:0]     lane;
    logic           fin;
    logic [TW-1:0]  tmo_cnt;
    logic [GW-1:0]  gap_cnt;

    logic           done_r;
    logic           pass_r;
    logic           timeout_r;
    logic [15:0]    err_count;
    logic [31:0]    err_addr;
    logic [31:0]    err_exp;
    logic [31:0]    err_got;

    logic           start_acc;
    logic           active;
    logic           xfer;
    logic           lane_last;
    logic           word_last;
    logic           gap_end;
    logic           tmo_hit;
    logic           miscmp;
    logic           pat_load;
    logic           pat_adv;
    logic [3:0]     mask;
    logic [31:0]    bmask;
    logic [31:0]    region;
    logic [31:0]    addr;
    logic [31:0]    pat;

    hbc_bist_pattern #(
        .SEED (SEED),
        .ROT  (ROT)
    ) u_pattern (
        .clk  (i_clk),
        .rst  (i_rst),
        .load (pat_load),
        .adv  (pat_adv),
        .pat  (pat)
    );

    always_comb begin
        start_acc = i_start && ((state == ST_IDLE) || (state == ST_DONE));
        active    = (state == ST_REQ) || (state == ST_WAIT);
        xfer      = active && i_mem_ready;
        case (cur_mode)
            MODE_BYTE: lane_last = (lane == 2'd3);
            MODE_HALF: lane_last = (lane == 2'd1);
            default:   lane_last = 1'b1;
        endcase
        word_last = (idx == IW'(NUM_WORDS - 1));
        gap_end   = (gap_cnt == GW'(GAP_CYCLES - 1));
        // Abort lands in DONE exactly TIMEOUT cycles after the request cycle.
        tmo_hit   = (state == ST_WAIT) && !i_mem_ready &&
                    ((32'(tmo_cnt) + 32'd2) >= 32'(TIMEOUT));
        mask      = lane_mask(cur_mode, lane);
        bmask     = byte_mask(mask);
        case (cur_mode)
            MODE_BYTE: region = BASE_ADDR;
            MODE_HALF: region = BASE_ADDR + HALF_OFS;
            default:   region = BASE_ADDR + WORD_OFS;
        endcase
        addr      = region + (32'(idx) << 2);
        miscmp    = rd_phase && ((i_mem_rdata & bmask) != (pat & bmask));
        pat_load  = start_acc || (xfer && lane_last && word_last);
        pat_adv   = xfer && lane_last && !word_last;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (i_start) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                state_nxt = i_mem_ready ? ST_GAP : ST_WAIT;
            end
            ST_WAIT: begin
                if (i_mem_ready)  state_nxt = ST_GAP;
                else if (tmo_hit) state_nxt = ST_DONE;
            end
            ST_GAP: begin
                if (gap_end) state_nxt = fin ? ST_DONE : ST_REQ;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = active || (state == ST_GAP);
        o_mem_valid = (state == ST_REQ) || ((VALID_PULSE == 0) && (state == ST_WAIT));
        o_mem_wstrb = 4'd0;
        o_mem_addr  = 32'd0;
        o_mem_wdata = 32'd0;
        if (active) begin
            o_mem_wstrb = rd_phase ? 4'd0 : mask;
            o_mem_addr  = addr;
            o_mem_wdata = pat;
        end
        o_done      = done_r;
        o_pass      = pass_r;
        o_timeout   = timeout_r;
        o_err_count = err_count;
        o_err_addr  = err_addr;
        o_err_exp   = err_exp;
        o_err_got   = err_got;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cur_mode  <= MODE_BYTE;
            last_mode <= MODE_BYTE;
            rd_phase  <= 1'b0;
            idx       <= '0;
            lane      <= 2'd0;
            fin       <= 1'b0;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            timeout_r <= 1'b0;
            err_count <= 16'd0;
            err_addr  <= 32'd0;
            err_exp   <= 32'd0;
            err_got   <= 32'd0;
        end else if (start_acc) begin
            cur_mode  <= (i_mode == MODE_ALL) ? MODE_BYTE : i_mode;
            last_mode <= (i_mode == MODE_ALL) ? MODE_WORD : i_mode;
            rd_phase  <= 1'b0;
            idx       <= '0;
            lane      <= 2'd0;
            fin       <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            timeout_r <= 1'b0;
            err_count <= 16'd0;
            err_addr  <= 32'd0;
            err_exp   <= 32'd0;
            err_got   <= 32'd0;
        end else begin
            if (state == ST_REQ) begin
                tmo_cnt <= '0;
            end else if (state == ST_WAIT) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (xfer) begin
                gap_cnt <= '0;
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end

            if (xfer) begin
                if (miscmp) begin
                    if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                    if (err_count == 16'd0) begin
                        err_addr <= addr;
                        err_exp  <= pat & bmask;
                        err_got  <= i_mem_rdata & bmask;
                    end
                end
                // Step lane, then word, then phase, then pass size.
                if (!lane_last) begin
                    lane <= lane + 2'd1;
                end else begin
                    lane <= 2'd0;
                    if (!word_last) begin
                        idx <= idx + IW'(1);
                    end else begin
                        idx <= '0;
                        if (!rd_phase) begin
                            rd_phase <= 1'b1;
                        end else if (cur_mode != last_mode) begin
                            rd_phase <= 1'b0;
                            cur_mode <= cur_mode + 2'd1;
                        end else begin
                            fin <= 1'b1;
                        end
                    end
                end
            end

            if (tmo_hit) begin
                done_r    <= 1'b1;
                timeout_r <= 1'b1;
                pass_r    <= 1'b0;
            end else if ((state == ST_GAP) && gap_end && fin) begin
                done_r <= 1'b1;
                pass_r <= (err_count == 16'd0);
            end
        end
    end

endmodule
